// File: rtl/bk_nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit Brent-Kung slice is reused once per nibble, LSB first.
// A registered carry links the nibbles. Operands and results move over valid/ready handshakes.

module brent_kung_cin (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [4:0] out_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic       g10;
    logic       p10;
    logic       g32;
    logic       p32;
    logic       g30;
    logic       p30;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Up-sweep: pair groups, then the full 4-bit group.
    assign g10 = g[1] | (p[1] & g[0]);
    assign p10 = p[1] & p[0];
    assign g32 = g[3] | (p[3] & g[2]);
    assign p32 = p[3] & p[2];
    assign g30 = g32 | (p32 & g10);
    assign p30 = p32 & p10;

    // Down-sweep: odd-position carry c3 comes from c2.
    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g10 | (p10 & cin_i);
    assign c[3] = g[2] | (p[2] & c[2]);
    assign c[4] = g30 | (p30 & cin_i);

    assign out_o = {c[4], p ^ c[3:0]};
endmodule

// state | meaning
// IDLE  | ready for operands; sum_o/cout_o hold the previous result
// RUN   | adding nibble idx_q with carry_q, one nibble per clock
// DONE  | result valid, held until the consumer accepts it
module bk_nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [4*NIBBLES-1:0]   a_i,
    input  logic [4*NIBBLES-1:0]   b_i,
    input  logic                   cin_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [4*NIBBLES-1:0]   sum_o,
    output logic                   cout_o,
    output logic                   busy_o
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_d;
    logic               carry_q;
    logic               carry_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   a_d;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   b_d;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_d;
    logic               cout_q;
    logic               cout_d;

    logic [3:0]         slice_a;
    logic [3:0]         slice_b;
    logic [4:0]         slice_out;
    logic               last_nibble;

    brent_kung_cin u_slice (
        .a_i   (slice_a),
        .b_i   (slice_b),
        .cin_i (carry_q),
        .out_o (slice_out)
    );

    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));

    always_comb begin
        slice_a = '0;
        slice_b = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx_q == IDX_W'(n)) begin
                slice_a = a_q[4*n +: 4];
                slice_b = b_q[4*n +: 4];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int n = 0; n < NIBBLES; n++) begin
                    if (idx_q == IDX_W'(n)) begin
                        sum_d[4*n +: 4] = slice_out[3:0];
                    end
                end
                carry_d = slice_out[4];
                if (last_nibble) begin
                    // Park the index at 0 so it never leaves 0..NIBBLES-1.
                    cout_d  = slice_out[4];
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready_o  = (state_q == ST_IDLE);
    assign busy_o      = (state_q == ST_RUN);
    assign out_valid_o = (state_q == ST_DONE);
    assign sum_o       = sum_q;
    assign cout_o      = cout_q;
endmodule

// File: tb/tb_bk_nibble_serial_adder.sv
// Bench for bk_nibble_serial_adder: directed cases plus random traffic.
// Every cycle is compared against a phase/countdown model that uses plain arithmetic.

module tb_bk_nibble_serial_adder;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic         cout;
    logic         busy;
    logic [W-1:0] sum;

    logic         in_valid1 = 1'b0;
    logic         out_ready1 = 1'b1;
    logic         cin1 = 1'b0;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         in_ready1;
    logic         out_valid1;
    logic         cout1;
    logic         busy1;
    logic [3:0]   sum1;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    time acc_t[$];
    int n_out_hs = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bk_nibble_serial_adder #(.NIBBLES(N)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .cin_i(cin),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum_o(sum), .cout_o(cout), .busy_o(busy)
    );

    bk_nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .a_i(a1), .b_i(b1), .cin_i(cin1),
        .out_valid_o(out_valid1), .out_ready_i(out_ready1),
        .sum_o(sum1), .cout_o(cout1), .busy_o(busy1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model: operation phase and remaining nibble count, result from a plain add.
    typedef enum {M_IDLE, M_RUN, M_DONE} mphase_e;
    mphase_e      m_ph = M_IDLE;
    int           m_left = 0;
    logic [W:0]   m_pend = '0;
    logic [W-1:0] m_sum = '0;
    logic         m_cout = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   = M_IDLE;
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else begin
            case (m_ph)
                M_IDLE: if (in_valid) begin
                    m_pend = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                    m_left = N;
                    m_ph   = M_RUN;
                end
                M_RUN: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_sum  = m_pend[W-1:0];
                        m_cout = m_pend[W];
                        m_ph   = M_DONE;
                    end
                end
                M_DONE: if (out_ready) m_ph = M_IDLE;
                default: m_ph = M_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) acc_t.push_back($time);
        if (rst_n && out_valid && out_ready) n_out_hs++;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            check("in_ready", 32'(in_ready), 32'(m_ph == M_IDLE));
            check("busy", 32'(busy), 32'(m_ph == M_RUN));
            check("out_valid", 32'(out_valid), 32'(m_ph == M_DONE));
            if (m_ph != M_RUN) begin
                check("sum", 32'(sum), 32'(m_sum));
                check("cout", 32'(cout), 32'(m_cout));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin tick(); t++; end
        if (!in_ready) check({nm, "_idle_timeout"}, 32'(in_ready), 32'd1);
    endtask

    task automatic wait_out(input string nm, output int t);
        t = 0;
        while (!out_valid && t < 100) begin tick(); t++; end
        if (!out_valid) check({nm, "_out_timeout"}, 32'(out_valid), 32'd1);
    endtask

    task automatic run_op(input string nm, input logic [15:0] av, input logic [15:0] bv,
                          input logic cv, input logic [15:0] es, input logic ec, input int hold);
        int  t;
        logic acc;
        a = av; b = bv; cin = cv; in_valid = 1'b1;
        t = 0; acc = 1'b0;
        while (!acc && t < 100) begin acc = in_ready; tick(); t++; end
        if (!acc) check({nm, "_accept_timeout"}, 32'(acc), 32'd1);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        out_ready = (hold == 0);
        wait_out(nm, t);
        check({nm, "_latency"}, 32'(t), 32'(N));
        check({nm, "_sum"}, 32'(sum), 32'(es));
        check({nm, "_cout"}, 32'(cout), 32'(ec));
        check({nm, "_model_sum"}, 32'(m_sum), 32'(es));
        if (hold > 0) begin
            repeat (hold) begin
                in_valid = 1'b1; a = 16'hAAAA; b = 16'($urandom);
                tick();
                in_valid = 1'b0;
                check({nm, "_held_sum"}, 32'(sum), 32'(es));
                check({nm, "_held_valid"}, 32'(out_valid), 32'd1);
            end
            out_ready = 1'b1;
            tick();
            check({nm, "_ready_after"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        int t;
        int base;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("basic", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 0);
        run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0);
        run_op("bp", 16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 5);

        // Back-to-back with in_valid held high: accepts N+2 cycles apart.
        wait_idle("b2b");
        out_ready = 1'b1;
        base = acc_t.size();
        a = 16'h0001; b = 16'h0001; cin = 1'b0; in_valid = 1'b1;
        t = 0;
        while (acc_t.size() < base + 1 && t < 100) begin tick(); t++; end
        a = 16'h8000; b = 16'h8000;
        wait_out("b2b0", t);
        check("b2b0_sum", 32'(sum), 32'h0002);
        check("b2b0_cout", 32'(cout), 32'd0);
        t = 0;
        while (acc_t.size() < base + 2 && t < 100) begin tick(); t++; end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(acc_t.size() - base), 32'd2);
        if (acc_t.size() >= base + 2)
            check("b2b_spacing", 32'((acc_t[base+1] - acc_t[base]) / 10), 32'(N + 2));
        wait_out("b2b1", t);
        check("b2b1_sum", 32'(sum), 32'h0000);
        check("b2b1_cout", 32'(cout), 32'd1);

        // Reset two cycles into an operation.
        tick();
        wait_idle("rst");
        a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("rst_busy_before", 32'(busy), 32'd1);
        tick(); tick();
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        run_op("post_rst", 16'h000F, 16'h0001, 1'b0, 16'h0010, 1'b0, 0);

        // Single-nibble instance.
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; in_valid1 = 1'b1;
        check("n1_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid1 = 1'b0;
        check("n1_busy", 32'(busy1), 32'd1);
        check("n1_not_valid", 32'(out_valid1), 32'd0);
        tick();
        check("n1_valid", 32'(out_valid1), 32'd1);
        check("n1_sum", 32'(sum1), 32'h1);
        check("n1_cout", 32'(cout1), 32'd1);
        tick();
        check("n1_idle", 32'(in_ready1), 32'd1);

        // Random traffic with random backpressure.
        base = n_out_hs;
        repeat (800) begin
            in_valid  = 1'($urandom);
            a         = 16'($urandom);
            b         = 16'($urandom);
            cin       = 1'($urandom);
            out_ready = (($urandom % 4) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (10) tick();
        check("random_results_seen", 32'(n_out_hs - base > 20), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
